// File: rtl/uart_mmio_ctrl.sv
// rtl/uart_mmio_ctrl.sv - memory-mapped UART front end: RX byte buffer, TX handshake FSM, CPU register decode
//
// Purpose: exposes a data register (load pops a received byte, store starts a
// transmission) and a status register {overrun, rx_avail, tx_ready} at two
// fixed CPU byte addresses.
//
// Build option: define UART_RX_FIFO_EN for an RX_DEPTH-entry receive FIFO;
// without it the receive buffer is a single holding register (depth 1).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cpu_addr            CPU byte address (exact match against DATA_ADDR/STAT_ADDR)
//   cpu_read_ce         load request, one access per cycle
//   cpu_write_ce        store request; wins over a simultaneous load
//   cpu_wdata           store data, only [7:0] used
//   cpu_rdata           combinational load data
//   cpu_stall           holds a data store while a transmission is in progress
//   rx_fin, rx_data     one-cycle pulse with a received byte
//   tx_write_ce         one-cycle pulse starting transmission of tx_wdata
//   tx_wdata            byte to transmit, stable until tx_fin
//   tx_fin              one-cycle pulse: transmission complete

module uart_mmio_ctrl #(
  parameter logic [31:0] DATA_ADDR = 32'hBFD003F8,
  parameter logic [31:0] STAT_ADDR = 32'hBFD003FC,
  parameter int          RX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_read_ce,
  input  logic        cpu_write_ce,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        rx_fin,
  input  logic [7:0]  rx_data,
  output logic        tx_write_ce,
  output logic [7:0]  tx_wdata,
  input  logic        tx_fin
);

  // Checked in both builds so a configuration stays valid when the FIFO is enabled.
  if ((RX_DEPTH < 2) || (RX_DEPTH > 64) || ((RX_DEPTH & (RX_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("RX_DEPTH must be a power of two in 2..64");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } tx_state_t;

  tx_state_t   r_state;
  logic        r_tx_write_ce;
  logic [7:0]  r_tx_wdata;
  logic        r_overrun;

  logic        w_data_hit;
  logic        w_stat_hit;
  logic        w_wr_data;
  logic        w_rd_data;
  logic        w_rd_stat;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic        w_empty;
  logic        w_full;
  logic [7:0]  w_head;
  logic [23:0] w_unused_wdata;

  assign w_unused_wdata = cpu_wdata[31:8];

  assign w_data_hit = (cpu_addr == DATA_ADDR);
  assign w_stat_hit = (cpu_addr == STAT_ADDR);

  // A store masks a simultaneous load entirely.
  assign w_wr_data = cpu_write_ce & w_data_hit;
  assign w_rd_data = cpu_read_ce & ~cpu_write_ce & w_data_hit;
  assign w_rd_stat = cpu_read_ce & ~cpu_write_ce & w_stat_hit;

  // A pop on the same edge frees the slot, so a full buffer still accepts the byte.
  assign w_pop  = w_rd_data & ~w_empty;
  assign w_push = rx_fin & (~w_full | w_pop);
  assign w_drop = rx_fin & w_full & ~w_pop;

  assign cpu_stall   = w_wr_data & (r_state != S_IDLE);
  assign tx_write_ce = r_tx_write_ce;
  assign tx_wdata    = r_tx_wdata;

  always_comb begin
    cpu_rdata = 32'd0;
    if (w_rd_stat) begin
      cpu_rdata = {29'd0, r_overrun, ~w_empty, (r_state == S_IDLE)};
    end else if (w_pop) begin
      cpu_rdata = {24'd0, w_head};
    end
  end

  // A fresh drop on the same edge as a status read stays visible to the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (w_rd_stat) begin
      r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_tx_write_ce <= 1'b0;
      r_tx_wdata    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_data) begin
            r_state       <= S_SEND;
            r_tx_write_ce <= 1'b1;
            r_tx_wdata    <= cpu_wdata[7:0];
          end
        end
        S_SEND: begin
          r_state       <= S_WAIT;
          r_tx_write_ce <= 1'b0;
        end
        S_WAIT: begin
          if (tx_fin) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_tx_write_ce <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int PW = $clog2(RX_DEPTH);

  logic [7:0]  r_mem [RX_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (PW + 1)'(RX_DEPTH));
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wptr] <= rx_data;
    end
  end

  // Pointers wrap naturally because RX_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (PW + 1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (PW + 1)'(1);
      end
    end
  end
`else
  logic [7:0] r_hold;
  logic       r_valid;

  assign w_empty = ~r_valid;
  assign w_full  = r_valid;
  assign w_head  = r_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold  <= 8'd0;
      r_valid <= 1'b0;
    end else if (w_push) begin
      r_hold  <= rx_data;
      r_valid <= 1'b1;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end
`endif

endmodule
